// File: rtl/wb_regs_pkg.sv
// Shared definitions for the Wishbone register-file responder: register indices, the ID default,
// the FSM state type and the byte-lane merge helper.
package wb_regs_pkg;

  localparam int unsigned REG_ID  = 0;
  localparam int unsigned REG_LED = 1;
  localparam int unsigned REG_CNT = 2;

  localparam logic [31:0] ID_DEFAULT = 32'hB0B0_0001;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] sel);
    logic [31:0] res;
    res = old_w;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) res[8*n +: 8] = new_w[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_regfile_slave.sv
// Pipelined Wishbone B4 responder: ID / LED / free-running counter / scratch registers with
// optional wait states, byte-lane writes and bus-error responses.
module wb_regfile_slave
  import wb_regs_pkg::*;
#(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [31:0]       i_wb_data,
  input  logic [3:0]        i_wb_sel,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic [31:0]       o_wb_data,
  output logic [7:0]        o_leds
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               pend_q, pend_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         sel_q;
  logic               ack_q, err_q;
  logic [31:0]        rdata_q;
  logic [31:0]        counter_q;
  logic [31:0]        regs_q [NREGS];

  logic               accept, respond, bad;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        rd_word;

  assign o_wb_stall = (state_q == BUSY);
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  // The pending request completes on the first edge back in IDLE, provided the cycle survived.
  assign respond    = pend_q & (state_q == IDLE) & i_wb_cyc;

  assign idx = addr_q[IDX_W-1:0];
  assign bad = (addr_q[ADDR_W-1:IDX_W] != '0) |
               (we_q & ((idx == IDX_W'(REG_ID)) | (idx == IDX_W'(REG_CNT))));

  always_comb begin
    rd_word = regs_q[idx];
    if (idx == IDX_W'(REG_ID))       rd_word = ID_VALUE;
    else if (idx == IDX_W'(REG_CNT)) rd_word = counter_q;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (WAIT_CYCLES != 0)) begin
          state_d = BUSY;
          wait_d  = CNT_W'(WAIT_CYCLES);
        end
      end
      BUSY: begin
        if (!i_wb_cyc || (wait_q == CNT_W'(1))) state_d = IDLE;
        else                                    wait_d  = wait_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (accept)                               pend_d = 1'b1;
    else if ((state_q == IDLE) || !i_wb_cyc) pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      pend_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      counter_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pend_q    <= pend_d;
      counter_q <= counter_q + 32'd1;
      ack_q     <= respond & ~bad;
      err_q     <= respond & bad;
      if (respond) begin
        rdata_q <= (bad || we_q) ? 32'd0 : rd_word;
        if (!bad && we_q) regs_q[idx] <= byte_merge(regs_q[idx], wdata_q, sel_q);
      end
      if (accept) begin
        we_q    <= i_wb_we;
        addr_q  <= i_wb_addr;
        wdata_q <= i_wb_data;
        sel_q   <= i_wb_sel;
      end
    end
  end

  // Responses are never presented once the master has dropped the cycle.
  assign o_wb_ack  = ack_q & i_wb_cyc;
  assign o_wb_err  = err_q & i_wb_cyc;
  assign o_wb_data = rdata_q;
  assign o_leds    = regs_q[IDX_W'(REG_LED)][7:0];

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Directed bench: a zero-wait instance driven from a vector table, and a three-wait instance for
// stall, abort and mid-access reset sequences.
module tb_wb_regfile_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, cyc0, stb0, we0, stall0, ack0, err0;
  logic [29:0] addr0;
  logic [31:0] wdat0, rdat0;
  logic [3:0]  sel0;
  logic [7:0]  leds0;

  logic        rst3, cyc3, stb3, we3, stall3, ack3, err3;
  logic [29:0] addr3;
  logic [31:0] wdat3, rdat3;
  logic [3:0]  sel3;
  logic [7:0]  leds3;

  wb_regfile_slave #(.ADDR_W(30), .NREGS(16), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_we(we0),
    .i_wb_addr(addr0), .i_wb_data(wdat0), .i_wb_sel(sel0), .o_wb_stall(stall0),
    .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_data(rdat0), .o_leds(leds0)
  );

  wb_regfile_slave #(.ADDR_W(30), .NREGS(16), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_reset(rst3), .i_wb_cyc(cyc3), .i_wb_stb(stb3), .i_wb_we(we3),
    .i_wb_addr(addr3), .i_wb_data(wdat3), .i_wb_sel(sel3), .o_wb_stall(stall3),
    .o_wb_ack(ack3), .o_wb_err(err3), .o_wb_data(rdat3), .o_leds(leds3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  leds;
  } vec_t;

  vec_t vecs[17];

  // Single zero-wait transaction: accept at edge T, response sampled just after edge T+1.
  task automatic access0(input vec_t v, input int n);
    @(negedge clk);
    cyc0 = 1'b1; stb0 = 1'b1; we0 = v.we; addr0 = v.addr; wdat0 = v.data; sel0 = v.sel;
    @(posedge clk); #1;
    check($sformatf("v%0d early_ack", n), {31'd0, ack0 | err0}, 32'd0);
    @(negedge clk);
    stb0 = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d ack", n), {31'd0, ack0}, {31'd0, v.ack});
    check($sformatf("v%0d err", n), {31'd0, err0}, {31'd0, v.err});
    check($sformatf("v%0d data", n), rdat0, v.rdata);
    check($sformatf("v%0d leds", n), {24'd0, leds0}, {24'd0, v.leds});
    @(negedge clk);
    cyc0 = 1'b0;
  endtask

  // Bounded transaction on the wait-state instance; a timeout leaves ack=err=0.
  task automatic access3(input logic we, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic ack, output logic err,
                         output logic [31:0] rd);
    ack = 1'b0; err = 1'b0; rd = '0;
    @(negedge clk);
    cyc3 = 1'b1; stb3 = 1'b1; we3 = we; addr3 = a; wdat3 = d; sel3 = s;
    @(posedge clk);
    @(negedge clk);
    stb3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack3 || err3) begin
        ack = ack3; err = err3; rd = rdat3;
        break;
      end
    end
    @(negedge clk);
    cyc3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic        a, e;
    logic [31:0] rd, prev;
    vec_t        v;

    vecs[0]  = '{1'b0, 30'd0,  32'h0,         4'hF, 1'b1, 1'b0, 32'hB0B0_0001, 8'h00};
    vecs[1]  = '{1'b1, 30'd1,  32'h0000_00A5, 4'hF, 1'b1, 1'b0, 32'h0,         8'hA5};
    vecs[2]  = '{1'b0, 30'd1,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_00A5, 8'hA5};
    vecs[3]  = '{1'b1, 30'd3,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0,         8'hA5};
    vecs[4]  = '{1'b1, 30'd3,  32'h1234_5678, 4'h5, 1'b1, 1'b0, 32'h0,         8'hA5};
    vecs[5]  = '{1'b0, 30'd3,  32'h0,         4'hF, 1'b1, 1'b0, 32'hFF34_FF78, 8'hA5};
    vecs[6]  = '{1'b0, 30'd16, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[7]  = '{1'b1, 30'd16, 32'h0000_DEAD, 4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[8]  = '{1'b1, 30'd0,  32'h0000_0001, 4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[9]  = '{1'b1, 30'd2,  32'h0000_0001, 4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[10] = '{1'b1, 30'd19, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[11] = '{1'b1, 30'h2000_0001, 32'h0,  4'hF, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[12] = '{1'b0, 30'd0,  32'h0,         4'hF, 1'b1, 1'b0, 32'hB0B0_0001, 8'hA5};
    vecs[13] = '{1'b1, 30'd3,  32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         8'hA5};
    vecs[14] = '{1'b0, 30'd3,  32'h0,         4'hF, 1'b1, 1'b0, 32'hFF34_FF78, 8'hA5};
    vecs[15] = '{1'b1, 30'd1,  32'h1234_5600, 4'h2, 1'b1, 1'b0, 32'h0,         8'hA5};
    vecs[16] = '{1'b0, 30'd1,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_56A5, 8'hA5};

    rst0 = 1'b1; cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0; addr0 = '0; wdat0 = '0; sel0 = '0;
    rst3 = 1'b1; cyc3 = 1'b0; stb3 = 1'b0; we3 = 1'b0; addr3 = '0; wdat3 = '0; sel3 = '0;

    #12;
    check("rst stall0", {31'd0, stall0}, 32'd0);
    check("rst ack0", {31'd0, ack0}, 32'd0);
    check("rst err0", {31'd0, err0}, 32'd0);
    check("rst data0", rdat0, 32'd0);
    check("rst leds0", {24'd0, leds0}, 32'd0);
    check("rst stall3", {31'd0, stall3}, 32'd0);
    check("rst leds3", {24'd0, leds3}, 32'd0);

    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    // Counter starts at 0 on release: edges e0, e1 (accept) then e2 samples value 2.
    v = '{1'b0, 30'd2, 32'h0, 4'hF, 1'b1, 1'b0, 32'd2, 8'h00};
    access0(v, 99);

    for (int i = 0; i < 17; i++) access0(vecs[i], i);

    // Back-to-back counter reads, one request per cycle.
    @(negedge clk);
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; addr0 = 30'd2; sel0 = 4'hF;
    prev = '0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b stall %0d", i), {31'd0, stall0}, 32'd0);
      if (i >= 1) begin
        check($sformatf("b2b ack %0d", i), {31'd0, ack0}, 32'd1);
        if (i >= 2) check($sformatf("b2b inc %0d", i), rdat0, prev + 32'd1);
        prev = rdat0;
      end
    end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;

    // Cycle dropped on the response edge: no response, no commit.
    @(negedge clk);
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; addr0 = 30'd4; wdat0 = 32'h5555_5555; sel0 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;
    @(posedge clk); #1;
    check("drop0 ack", {31'd0, ack0 | err0}, 32'd0);
    v = '{1'b0, 30'd4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 8'hA5};
    access0(v, 100);

    // Wait-state timing: stall after T, T+1, T+2; idle after T+3; ack after T+4.
    @(negedge clk);
    cyc3 = 1'b1; stb3 = 1'b1; we3 = 1'b0; addr3 = 30'd0; sel3 = 4'hF;
    @(posedge clk); #1;
    check("w3 stall T", {31'd0, stall3}, 32'd1);
    check("w3 ack T", {31'd0, ack3}, 32'd0);
    @(negedge clk);
    stb3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("w3 stall T+%0d", k), {31'd0, stall3}, (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("w3 ack T+%0d", k), {31'd0, ack3 | err3}, 32'd0);
    end
    @(posedge clk); #1;
    check("w3 ack T+4", {31'd0, ack3}, 32'd1);
    check("w3 err T+4", {31'd0, err3}, 32'd0);
    check("w3 data T+4", rdat3, 32'hB0B0_0001);
    @(posedge clk); #1;
    check("w3 ack T+5", {31'd0, ack3}, 32'd0);
    @(negedge clk);
    cyc3 = 1'b0;

    access3(1'b1, 30'd6, 32'hA1B2_C3D4, 4'hC, a, e, rd);
    check("w3 wr ack", {31'd0, a}, 32'd1);
    access3(1'b0, 30'd6, 32'h0, 4'hF, a, e, rd);
    check("w3 rd ack", {31'd0, a}, 32'd1);
    check("w3 rd data", rd, 32'hA1B2_0000);

    // Abort while busy: cyc low at edge T+2.
    @(negedge clk);
    cyc3 = 1'b1; stb3 = 1'b1; we3 = 1'b1; addr3 = 30'd3; wdat3 = 32'hCAFE_F00D; sel3 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    stb3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc3 = 1'b0;
    @(posedge clk); #1;
    check("abort stall", {31'd0, stall3}, 32'd0);
    @(negedge clk);
    cyc3 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort no_resp %0d", k), {31'd0, ack3 | err3}, 32'd0);
    end
    @(negedge clk);
    cyc3 = 1'b0;
    access3(1'b0, 30'd3, 32'h0, 4'hF, a, e, rd);
    check("abort rd ack", {31'd0, a}, 32'd1);
    check("abort rd data", rd, 32'h0);

    // Reset mid-access discards the pending write and clears the LEDs.
    access3(1'b1, 30'd1, 32'h0000_003C, 4'h1, a, e, rd);
    check("w3 leds", {24'd0, leds3}, 32'h3C);
    @(negedge clk);
    cyc3 = 1'b1; stb3 = 1'b1; we3 = 1'b1; addr3 = 30'd5; wdat3 = 32'h7777_7777; sel3 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    stb3 = 1'b0; rst3 = 1'b1;
    #1;
    check("midrst stall", {31'd0, stall3}, 32'd0);
    check("midrst leds", {24'd0, leds3}, 32'd0);
    check("midrst ack", {31'd0, ack3 | err3}, 32'd0);
    @(negedge clk);
    rst3 = 1'b0; cyc3 = 1'b0;
    access3(1'b0, 30'd5, 32'h0, 4'hF, a, e, rd);
    check("midrst rd ack", {31'd0, a}, 32'd1);
    check("midrst rd data", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
